// File: rtl/mult_pkg.sv
// Shared types for the radix-2 Booth multiplier: datapath control bundle,
// controller state encoding and the default operand width.
package mult_pkg;

    localparam int MULT_N = 8;

    typedef struct packed {
        logic load_A;
        logic load_B;
        logic load_add;
        logic add_sub;
        logic shift_HQ_LQ;
    } mult_control_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        OP,
        SHIFT,
        DONE
    } mult_state_t;

endpackage

// File: rtl/mult_booth_ctrl.sv
// Control FSM for the radix-2 Booth datapath: LOAD, then N x (OP, SHIFT), then DONE.
// Latency is fixed; Q_LSB only selects add/subtract/nothing in OP.
module mult_booth_ctrl
    import mult_pkg::*;
#(
    parameter int N  = MULT_N,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    Q_LSB,
    output mult_control_t mult_control,
    output logic          busy,
    output logic          done,
    output logic          result_valid
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    mult_state_t   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          rv_nx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            result_valid <= rv_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        rv_nx        = result_valid;
        mult_control = '0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = LOAD;
                    rv_nx    = 1'b0;
                end
            end
            LOAD: begin
                mult_control.load_A = 1'b1;
                mult_control.load_B = 1'b1;
                cnt_nx              = '0;
                state_nx            = OP;
            end
            OP: begin
                // 00/11 still burn the OP cycle so every operand pair takes the same time
                case (Q_LSB)
                    2'b01: mult_control.load_add = 1'b1;
                    2'b10: begin
                        mult_control.load_add = 1'b1;
                        mult_control.add_sub  = 1'b1;
                    end
                    default: ;
                endcase
                state_nx = SHIFT;
            end
            SHIFT: begin
                mult_control.shift_HQ_LQ = 1'b1;
                if (cnt == LAST) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx   = cnt + 1'b1;
                    state_nx = OP;
                end
            end
            DONE: begin
                done     = 1'b1;
                rv_nx    = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule
